// File: rtl/aes_loader_pkg.sv
// Shared state encoding, block geometry and defaults for the AES block loader
// and its word pack/unpack registers.
package aes_loader_pkg;

  typedef enum logic [1:0] {FILL, LOAD, WAIT, DRAIN} state_t;

  localparam int WORD_W             = 32;
  localparam int WORDS_PER_BLOCK    = 4;
  localparam int BLOCK_W            = WORD_W * WORDS_PER_BLOCK;
  localparam int SLOT_W             = $clog2(WORDS_PER_BLOCK);
  localparam int TIMEOUT_CYCLES_DEF = 64;

  // Slot 0 is the most-significant word of the block.
  function automatic int slot_lsb(input logic [SLOT_W-1:0] s);
    return (WORDS_PER_BLOCK - 1 - int'(s)) * WORD_W;
  endfunction

endpackage

// File: rtl/aes_word_serdes.sv
// Four-slot 32<->128 pack/unpack register with a slot counter: words are
// written slot by slot, or a whole block is loaded and read back word by word.
module aes_word_serdes
  import aes_loader_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_word_we,
  input  logic [WORD_W-1:0]  i_word,
  input  logic               i_par_we,
  input  logic [BLOCK_W-1:0] i_par,
  input  logic               i_adv,
  output logic [BLOCK_W-1:0] o_par,
  output logic [WORD_W-1:0]  o_word,
  output logic [SLOT_W-1:0]  o_slot
);

  logic [BLOCK_W-1:0] r_data;
  logic [WORD_W-1:0]  r_word;
  logic [SLOT_W-1:0]  r_slot;
  logic [SLOT_W-1:0]  w_next_slot;

  assign w_next_slot = r_slot + 1'b1;

  // r_word always mirrors the slot about to be read, so the word output is a flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_word <= '0;
      r_slot <= '0;
    end else if (i_par_we) begin
      r_data <= i_par;
      r_word <= i_par[BLOCK_W-1 -: WORD_W];
      r_slot <= '0;
    end else if (i_word_we) begin
      r_data[slot_lsb(r_slot) +: WORD_W] <= i_word;
      r_slot <= w_next_slot;
    end else if (i_adv) begin
      r_word <= r_data[slot_lsb(w_next_slot) +: WORD_W];
      r_slot <= w_next_slot;
    end
  end

  assign o_par  = r_data;
  assign o_word = r_word;
  assign o_slot = r_slot;

endmodule

// File: rtl/aes_block_loader.sv
// Valid/ready word front end for aes_cipher_top: packs plaintext, pulses ld,
// waits for done and streams the ciphertext. Optional WAIT watchdog: AES_LOADER_TIMEOUT_EN.
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_key_we,
  input  logic [BLOCK_W-1:0] i_key_in,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WORD_W-1:0]  i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WORD_W-1:0]  o_out_data,
  output logic               o_aes_ld,
  input  logic               i_aes_done,
  output logic [BLOCK_W-1:0] o_aes_key,
  output logic [BLOCK_W-1:0] o_aes_text_in,
  input  logic [BLOCK_W-1:0] i_aes_text_out,
  output logic               o_busy,
  output logic [15:0]        o_blk_cnt,
  output logic               o_err
);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_aes_ld;
  logic               r_busy;
  logic [15:0]        r_blk_cnt;
  logic [BLOCK_W-1:0] r_key;

  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_in_last;
  logic               w_out_last;
  logic               w_capture;
  logic [SLOT_W-1:0]  w_wcnt;
  logic [SLOT_W-1:0]  w_ocnt;
  logic [BLOCK_W-1:0] w_unused_par;
  logic [WORD_W-1:0]  w_unused_word;

  assign w_in_hs    = i_in_valid && r_in_ready;
  assign w_out_hs   = r_out_valid && i_out_ready;
  assign w_in_last  = (w_wcnt == SLOT_W'(WORDS_PER_BLOCK - 1));
  assign w_out_last = (w_ocnt == SLOT_W'(WORDS_PER_BLOCK - 1));
  assign w_capture  = (r_state == WAIT) && i_aes_done;

  aes_word_serdes u_pack (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_word_we (w_in_hs),
    .i_word    (i_in_data),
    .i_par_we  (1'b0),
    .i_par     ('0),
    .i_adv     (1'b0),
    .o_par     (o_aes_text_in),
    .o_word    (w_unused_word),
    .o_slot    (w_wcnt)
  );

  aes_word_serdes u_unpack (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_word_we (1'b0),
    .i_word    ('0),
    .i_par_we  (w_capture),
    .i_par     (i_aes_text_out),
    .i_adv     (w_out_hs),
    .o_par     (w_unused_par),
    .o_word    (o_out_data),
    .o_slot    (w_ocnt)
  );

  // A new key may only land before the first word, so the cipher key never changes mid-block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key <= '0;
    end else if (i_key_we && (r_state == FILL) && (w_wcnt == '0)) begin
      r_key <= i_key_in;
    end
  end

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_err;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= FILL;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_aes_ld    <= 1'b0;
      r_busy      <= 1'b0;
      r_blk_cnt   <= '0;
`ifdef AES_LOADER_TIMEOUT_EN
      r_tcnt      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_hs && w_in_last) begin
            r_state    <= LOAD;
            r_in_ready <= 1'b0;
            r_aes_ld   <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        LOAD: begin
          r_state  <= WAIT;
          r_aes_ld <= 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
          r_tcnt   <= '0;
`endif
        end
        WAIT: begin
          if (i_aes_done) begin
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_blk_cnt   <= r_blk_cnt + 16'd1;
          end
`ifdef AES_LOADER_TIMEOUT_EN
          // done has priority: a result arriving on the last allowed cycle is kept.
          else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_state    <= FILL;
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (w_out_hs && w_out_last) begin
            r_state     <= FILL;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_aes_ld    = r_aes_ld;
  assign o_aes_key   = r_key;
  assign o_busy      = r_busy;
  assign o_blk_cnt   = r_blk_cnt;
`ifdef AES_LOADER_TIMEOUT_EN
  assign o_err       = r_err;
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Stream-side controller that sits directly upstream and downstream of `aes_cipher_top`. It assembles four 32-bit plaintext words into a 128-bit block, holds the block and key stable on the cipher inputs, and issues a single-cycle `ld`. It then waits for `done`, captures `text_out`, and streams the ciphertext back out as four 32-bit words. Together with the cipher core, it replaces the manual bench sequencing of key, text, `ld` and `done` with a valid/ready word interface.

## Interface
- `TIMEOUT_CYCLES`, 64: `WAIT` cycles before abort. Only used with `AES_LOADER_TIMEOUT_EN`.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `key_we` in 1: load `key_in` into the key register.
- `key_in` in 128: cipher key.
- `in_valid` in 1: plaintext word valid.
- `in_ready` out 1: block accepts a plaintext word.
- `in_data` in 32: plaintext word, most-significant word first.
- `out_valid` out 1: ciphertext word valid.
- `out_ready` in 1: consumer accepts a ciphertext word.
- `out_data` out 32: ciphertext word, most-significant word first.
- `aes_ld` out 1: to cipher `ld`.
- `aes_done` in 1: from cipher `done`.
- `aes_key` out 128: to cipher `key`.
- `aes_text_in` out 128: to cipher `text_in`.
- `aes_text_out` in 128: from cipher `text_out`.
- `busy` out 1: high in `LOAD`, `WAIT` and `DRAIN`.
- `blk_cnt` out 16: count of completed blocks; wraps 0xFFFF→0.
- `err` out 1: sticky timeout flag. Tied 0 without the macro.

## Operation
- FSM states: `FILL`, `LOAD`, `WAIT`, `DRAIN`. Reset state is `FILL`.
- **`FILL`**
  - `in_ready`=1.
  - Each handshake (`in_valid && in_ready`) shifts `in_data` into the block register at the word slot given by 2-bit `wcnt`: slot 0 is [127:96], slot 3 is [31:0].
  - Handshake with `wcnt`==3 → `LOAD`, `wcnt`→0.
- **`LOAD`**
  - `aes_ld`=1 for exactly one cycle, then → `WAIT`.
  - `aes_text_in` and `aes_key` are held constant from `LOAD` until `DRAIN` exits.
- **`WAIT`**
  - `aes_done`==1 sampled → capture `aes_text_out` into the output register, `blk_cnt`+1, → `DRAIN`.
- **`DRAIN`**
  - `out_valid`=1, `out_data` = output slot `ocnt` (slot 0 is [127:96]).
  - Each `out_valid && out_ready` handshake increments `ocnt`.
  - Handshake with `ocnt`==3 → `FILL`.
- No overlap: `in_ready`=0 outside `FILL`. Plaintext for the next block waits until the drain completes.
- **Key register**
  - `key_we` is honoured only in `FILL` with `wcnt`==0. In any other state or slot it is silently ignored.
  - `key_we` together with a first-word handshake in the same cycle: both take effect.
- `aes_done` asserted outside `WAIT` is ignored.
- **Reset mid-operation:** any state → `FILL` on the next edge; all counters and registers return to reset values. A partially assembled block or undrained ciphertext is discarded.

## Timing
- All outputs are registered.
- Reset values: `in_ready` 0, `out_valid` 0, `out_data` 0, `aes_ld` 0, `aes_key` 0, `aes_text_in` 0, `busy` 0, `blk_cnt` 0, `err` 0.
- `in_ready`=1 from the first cycle after `rst` deasserts.
- 4th input handshake at edge t → `aes_ld`=1 during cycle t+1, 0 from t+2.
- `aes_done` sampled high at edge d → `out_valid`=1 from d+1, first word already valid.
- With `out_ready` tied high, the drain takes 4 cycles. Last drain handshake at edge e → `in_ready`=1 from e+1.
- Block round trip (all handshakes back-to-back) = 4 fill + 1 load + cipher latency + 4 drain cycles.

## Configuration
- Macro: `AES_LOADER_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter runs in `WAIT`.
  - If `aes_done` is not seen within `TIMEOUT_CYCLES` cycles of entering `WAIT`, set `err`=1 (sticky until `rst`) and go to `FILL` without draining. `blk_cnt` is not incremented.
  - `aes_done` and timeout in the same cycle: `aes_done` wins.
- **Undefined:** no counter; `WAIT` waits indefinitely; `err` is constant 0.

## Structure
- Shared package `aes_loader_pkg` holds:
  - state encoding typedef (`FILL`/`LOAD`/`WAIT`/`DRAIN`);
  - word width (32) and words-per-block (4) constants;
  - default `TIMEOUT_CYCLES`.
- One sub-module: `aes_word_serdes`, a 4-slot 32↔128 pack/unpack register with a slot counter, instantiated twice (input pack, output unpack).
- FSM, key register, `blk_cnt` and timeout logic stay in the top module.

## Test plan
- **Basic block:**
  - Stimulus: key `cafebabedeadbeefdeadbeef00000000`; words `bba47f76`, `875f634a`, `85d6fe52`, `004297b4`; behavioural cipher with `done` 12 cycles after `ld`, returning `0123456789abcdeffedcba9876543210`.
  - Required response: `aes_text_in`=`bba47f76875f634a85d6fe52004297b4` at `aes_ld`; one `aes_ld` pulse; out words `01234567`, `89abcdef`, `fedcba98`, `76543210`; `blk_cnt`=1.
- **Backpressure:** `out_ready` toggling 1/0 each cycle during drain → each word held stable until its handshake; no words lost or duplicated; `in_ready`=0 until the 4th handshake.
- **Key gating:** `key_we` with key `11…11` asserted in `WAIT` → `aes_key` unchanged. Asserted in `FILL` with `wcnt`==0 → `aes_key`=`11…11` on the next block.
- **Reset mid-block:** `rst` pulsed after 2 input words → `in_ready`=0 during `rst`; after release, the next 4 words form a fresh block; `blk_cnt`=0.
- **Timeout** (macro on, `TIMEOUT_CYCLES`=64, cipher never asserts `done`) → `err`=1 after 64 `WAIT` cycles; state `FILL`; `out_valid` never asserted; `blk_cnt` unchanged.
- **Counter wrap:** preload via 65536 blocks, or force `blk_cnt`=0xFFFF then complete one block → `blk_cnt`=0x0000.
